// File: rtl/l2_cache_pkg.sv
// Shared types and constants for the set-associative L2 cache.
package l2_cache_pkg;

    // Controller states. IDLE is the only state that accepts a request.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WB        = 3'd2,
        FILL      = 3'd3,
        FILL_WAIT = 3'd4,
        ALLOC     = 3'd5,
        RESP      = 3'd6
    } state_t;

    // Memory-side operation encoding carried on mem_req_we.
    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    // Requester-side hit flag encoding carried on resp_hit.
    localparam logic RESP_MISS = 1'b0;
    localparam logic RESP_HIT  = 1'b1;

    // Default geometry; the top module recomputes these from its own parameters.
    localparam int DEF_SETS   = 512;
    localparam int DEF_WAYS   = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_IDX_W  = $clog2(DEF_SETS);
    localparam int DEF_TAG_W  = DEF_ADDR_W - 2 - DEF_IDX_W;

    // Reference layout of one cache line at the default geometry. The top keeps
    // the same fields in separate arrays so valid/dirty can be cleared in one
    // cycle while tag/data stay reset-free.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_DATA_W-1:0] data;
    } line_t;

endpackage

// File: rtl/l2_lru_ages.sv
// True-LRU age update for one set: the accessed way becomes youngest (0) and
// every way that was younger than it ages by one. Also reports the oldest way.
module l2_lru_ages #(
    parameter int WAYS  = 2,
    parameter int AGE_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages_i,
    input  logic [AGE_W-1:0]           way_i,
    output logic [WAYS-1:0][AGE_W-1:0] ages_o,
    output logic [AGE_W-1:0]           oldest_o
);

    logic [AGE_W-1:0] acc_age;

    // Age update and oldest-way search; ages are a permutation so exactly one way matches WAYS-1.
    always_comb begin
        acc_age  = ages_i[way_i];
        ages_o   = ages_i;
        oldest_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages_i[w] < acc_age) begin
                ages_o[w] = ages_i[w] + AGE_W'(1);
            end
            if (ages_i[w] == AGE_W'(WAYS - 1)) begin
                oldest_o = AGE_W'(w);
            end
        end
        ages_o[way_i] = '0;
    end

endmodule

// File: rtl/l2_cache_assoc.sv
// N-way set-associative, write-back, write-allocate L2 with one word per line.
// Handshakes: a transfer happens on any rising edge where valid && ready are both
// high; the sender holds its payload stable while valid is high and ready is low.
// The response channel has no ready: resp_valid is a single-cycle pulse.
module l2_cache_assoc
    import l2_cache_pkg::*;
#(
    parameter int SETS   = 512,
    parameter int WAYS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output state_t            dbg_state
);

    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    // Byte-offset bits never select anything in a word-per-line cache.
    logic unused_byte_off;
    assign unused_byte_off = ^req_addr[1:0];

    // Line storage; valid/dirty/age are reset, tag/data are not.
    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS-1:0]             dirty_q [SETS];
    logic [WAYS-1:0][AGE_W-1:0]  age_q   [SETS];
    logic [TAG_W-1:0]            tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]           data_q  [SETS][WAYS];

    // Controller and captured request.
    state_t              state_q;
    logic                req_we_q;
    logic [IDX_W-1:0]    req_idx_q;
    logic [TAG_W-1:0]    req_tag_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [AGE_W-1:0]    victim_q;

    // Registered outputs.
    logic                req_ready_q, resp_valid_q, resp_hit_q;
    logic [DATA_W-1:0]   resp_data_q, mem_wdata_q;
    logic                mem_req_valid_q, mem_req_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

    // Lookup of the captured set.
    logic [WAYS-1:0]             set_valid, set_dirty;
    logic [WAYS-1:0][AGE_W-1:0]  set_ages, ages_upd;
    logic                        hit, inv_found, victim_dirty;
    logic [AGE_W-1:0]            hit_way, inv_way, oldest_way, victim_way, acc_way;

    // Storage write controls.
    logic                line_we, line_dirty, age_we;
    logic [AGE_W-1:0]    line_way;
    logic [DATA_W-1:0]   line_data;

    // Tag compare (lowest matching way wins) and lowest invalid way search.
    always_comb begin
        set_valid = valid_q[req_idx_q];
        set_dirty = dirty_q[req_idx_q];
        set_ages  = age_q[req_idx_q];
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && set_valid[w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!inv_found && !set_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
        end
    end

    // The way touched this cycle: the hit way during LOOKUP, otherwise the chosen victim.
    assign acc_way = (state_q == LOOKUP) ? hit_way : victim_q;

    l2_lru_ages #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .ages_i   (set_ages),
        .way_i    (acc_way),
        .ages_o   (ages_upd),
        .oldest_o (oldest_way)
    );

    assign victim_way   = inv_found ? inv_way : oldest_way;
    assign victim_dirty = set_valid[victim_way] && set_dirty[victim_way];

    // Decide which line (if any) is written this cycle and whether the set's ages move.
    always_comb begin
        line_we    = 1'b0;
        line_dirty = 1'b0;
        line_way   = victim_q;
        line_data  = req_wdata_q;
        age_we     = 1'b0;
        case (state_q)
            LOOKUP: begin
                if (hit) begin
                    age_we   = 1'b1;
                    line_way = hit_way;
                    if (req_we_q) begin
                        line_we    = 1'b1;
                        line_dirty = 1'b1;
                    end
                end
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    line_we   = 1'b1;
                    line_data = mem_resp_data;
                    age_we    = 1'b1;
                end
            end
            ALLOC: begin
                line_we    = 1'b1;
                line_dirty = 1'b1;
                age_we     = 1'b1;
            end
            default: ;
        endcase
    end

    // Valid, dirty and LRU ages: cleared to an empty set with ages 0..WAYS-1 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            if (line_we) begin
                valid_q[req_idx_q][line_way] <= 1'b1;
                dirty_q[req_idx_q][line_way] <= line_dirty;
            end
            if (age_we) begin
                age_q[req_idx_q] <= ages_upd;
            end
        end
    end

    // Tag and data payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[req_idx_q][line_way]  <= req_tag_q;
            data_q[req_idx_q][line_way] <= line_data;
        end
    end

    // Request controller with registered outputs and saturating hit/miss counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            req_we_q        <= 1'b0;
            req_idx_q       <= '0;
            req_tag_q       <= '0;
            req_wdata_q     <= '0;
            victim_q        <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_hit_q      <= RESP_MISS;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= MEM_OP_READ;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_we_q    <= req_we;
                        req_idx_q   <= req_addr[IDX_W+1:2];
                        req_tag_q   <= req_addr[ADDR_W-1:IDX_W+2];
                        req_wdata_q <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        resp_data_q  <= req_we_q ? '0 : data_q[req_idx_q][hit_way];
                        resp_hit_q   <= RESP_HIT;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        victim_q   <= victim_way;
                        resp_hit_q <= RESP_MISS;
                        if (victim_dirty) begin
                            mem_req_valid_q <= 1'b1;
                            mem_req_we_q    <= MEM_OP_WRITE;
                            mem_addr_q      <= {tag_q[req_idx_q][victim_way], req_idx_q, 2'b00};
                            mem_wdata_q     <= data_q[req_idx_q][victim_way];
                            state_q         <= WB;
                        end else if (req_we_q) begin
                            state_q <= ALLOC;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_req_we_q    <= MEM_OP_READ;
                            mem_addr_q      <= {req_tag_q, req_idx_q, 2'b00};
                            state_q         <= FILL;
                        end
                    end
                end
                WB: begin
                    if (mem_req_ready) begin
                        mem_req_we_q <= MEM_OP_READ;
                        if (req_we_q) begin
                            mem_req_valid_q <= 1'b0;
                            state_q         <= ALLOC;
                        end else begin
                            mem_addr_q <= {req_tag_q, req_idx_q, 2'b00};
                            state_q    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        resp_data_q  <= mem_resp_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                ALLOC: begin
                    resp_data_q  <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_hit      = resp_hit_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Directed bench for l2_cache_assoc: 16 sets x 4 ways, with a small memory
// model that can stall the request channel and delay fill data.
module tb_l2_cache_assoc;
  import l2_cache_pkg::*;

  localparam int SETS = 16;
  localparam int WAYS = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_hit;
  logic [DW-1:0] resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [CW-1:0] hit_cnt, miss_cnt;
  state_t        dbg_state;

  l2_cache_assoc #(
    .SETS(SETS), .WAYS(WAYS), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // memory model: log entries are {we, addr, wdata}
  int            stall_left   = 0;
  int            stall_cycles = 0;
  int            mem_lat      = 3;
  int            lat_left     = 0;
  bit            stalling     = 0;
  bit            unstable     = 0;
  logic [AW-1:0] ref_addr;
  logic [DW-1:0] ref_data;
  logic          ref_we;
  logic [DW-1:0] fill_data    = '0;
  logic [64:0]   mem_log_q[$];

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (reset) begin
        lat_left      = 0;
        mem_req_ready = 1'b0;
        stalling      = 0;
      end else begin
        if (lat_left > 0) begin
          lat_left--;
          if (lat_left == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = fill_data;
          end
        end
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            if (!stalling) begin
              stalling = 1;
              ref_addr = mem_addr;
              ref_data = mem_wdata;
              ref_we   = mem_req_we;
            end else if (mem_addr !== ref_addr || mem_wdata !== ref_data || mem_req_we !== ref_we) begin
              unstable = 1;
            end
            if (req_ready) unstable = 1;
            stall_cycles++;
            stall_left--;
            mem_req_ready = 1'b0;
          end else begin
            if (stalling && (mem_addr !== ref_addr || mem_wdata !== ref_data)) unstable = 1;
            stalling      = 0;
            mem_req_ready = 1'b1;
            mem_log_q.push_back({mem_req_we, mem_addr, mem_wdata});
            if (!mem_req_we) lat_left = mem_lat;
          end
        end else begin
          mem_req_ready = 1'b0;
        end
      end
    end
  end

  // driver tasks (called at a negedge)
  logic [DW-1:0] r_data;
  logic          r_hit;
  int            r_lat;

  task automatic start_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check_val("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n;
    start_req(we, addr, wdata);
    r_lat = 1;
    n = 0;
    while (!resp_valid && n < 300) begin @(negedge clk); r_lat++; n++; end
    check_val("resp_seen", resp_valid, 1);
    r_data = resp_data;
    r_hit  = resp_hit;
    @(negedge clk);
    check_val("resp_one_cycle", resp_valid, 0);
  endtask

  // expected response data goes through exp_q so ordering mistakes show up
  task automatic expect_resp(input string tag, input logic [DW-1:0] exp_data, input logic exp_hit);
    exp_q.push_back(exp_data);
    check_val({tag, "_data"}, r_data, exp_q.pop_front());
    check_val({tag, "_hit"}, r_hit, exp_hit);
  endtask

  initial begin
    logic [64:0] e;
    int n;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // reset values
    repeat (2) @(negedge clk);
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_resp_data", resp_data, 0);
    check_val("rst_resp_hit", resp_hit, 0);
    check_val("rst_mem_req_valid", mem_req_valid, 0);
    check_val("rst_mem_req_we", mem_req_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_hit_cnt", hit_cnt, 0);
    check_val("rst_miss_cnt", miss_cnt, 0);
    reset = 1'b0;

    // cold read miss with 3-cycle memory
    fill_data = 32'hDEAD_BEEF;
    mem_lat   = 3;
    mem_log_q.delete();
    do_req(1'b0, 32'h0000_1000, '0);
    expect_resp("cold_read", 32'hDEAD_BEEF, 1'b0);
    check_val("cold_lat", r_lat, 6);
    check_val("cold_mem_ops", mem_log_q.size(), 1);
    e = mem_log_q[0];
    check_val("cold_fill_we", e[64], 0);
    check_val("cold_fill_addr", e[63:32], 32'h0000_1000);
    check_val("cold_miss_cnt", miss_cnt, 1);

    // repeat read hits in 2 cycles with no memory traffic
    mem_log_q.delete();
    do_req(1'b0, 32'h0000_1000, '0);
    expect_resp("hit_read", 32'hDEAD_BEEF, 1'b1);
    check_val("hit_lat", r_lat, 2);
    check_val("hit_mem_ops", mem_log_q.size(), 0);
    check_val("hit_cnt_1", hit_cnt, 1);

    // write hit dirties way0, then writes fill ways 1..3 of set 0
    do_req(1'b1, 32'h0000_1000, 32'h1111_1111);
    expect_resp("wr_hit", 32'h0, 1'b1);
    do_req(1'b1, 32'h0000_2000, 32'h2222_2222);
    expect_resp("wr_2000", 32'h0, 1'b0);
    do_req(1'b1, 32'h0000_3000, 32'h3333_3333);
    expect_resp("wr_3000", 32'h0, 1'b0);
    do_req(1'b1, 32'h0000_4000, 32'h4444_4444);
    expect_resp("wr_4000", 32'h0, 1'b0);
    check_val("alloc_mem_ops", mem_log_q.size(), 0);

    // fifth tag evicts dirty 0x1000 (oldest); memory stalls the writeback 5 cycles
    mem_log_q.delete();
    stall_cycles = 0;
    unstable     = 0;
    stall_left   = 5;
    do_req(1'b1, 32'h0000_5000, 32'h5555_5555);
    expect_resp("wr_5000", 32'h0, 1'b0);
    check_val("wb_stall_cycles", stall_cycles, 5);
    check_val("wb_stable", unstable, 0);
    check_val("wb_mem_ops", mem_log_q.size(), 1);
    e = mem_log_q[0];
    check_val("wb_we", e[64], 1);
    check_val("wb_addr", e[63:32], 32'h0000_1000);
    check_val("wb_data", e[31:0], 32'h1111_1111);

    // touch 0x2000 so 0x3000 becomes oldest; a new read tag must evict it
    do_req(1'b0, 32'h0000_2000, '0);
    expect_resp("rd_2000", 32'h2222_2222, 1'b1);
    mem_log_q.delete();
    fill_data = 32'h6666_6666;
    do_req(1'b0, 32'h0000_6000, '0);
    expect_resp("rd_6000", 32'h6666_6666, 1'b0);
    check_val("lru_mem_ops", mem_log_q.size(), 2);
    e = mem_log_q[0];
    check_val("lru_wb_addr", e[63:32], 32'h0000_3000);
    check_val("lru_wb_data", e[31:0], 32'h3333_3333);
    e = mem_log_q[1];
    check_val("lru_fill_we", e[64], 0);
    check_val("lru_fill_addr", e[63:32], 32'h0000_6000);
    do_req(1'b0, 32'h0000_5000, '0);
    expect_resp("rd_5000", 32'h5555_5555, 1'b1);
    do_req(1'b0, 32'h0000_4000, '0);
    expect_resp("rd_4000", 32'h4444_4444, 1'b1);
    check_val("hit_cnt_5", hit_cnt, 5);
    check_val("miss_cnt_6", miss_cnt, 6);

    // reset while waiting for fill data abandons the request
    mem_log_q.delete();
    mem_lat = 20;
    start_req(1'b0, 32'h0000_7004, '0);
    n = 0;
    while (mem_log_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check_val("pre_rst_state", dbg_state, FILL_WAIT);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_req_ready", req_ready, 1);
    check_val("mid_rst_resp_valid", resp_valid, 0);
    check_val("mid_rst_mem_req_valid", mem_req_valid, 0);
    check_val("mid_rst_mem_addr", mem_addr, 0);
    check_val("mid_rst_hit_cnt", hit_cnt, 0);
    check_val("mid_rst_miss_cnt", miss_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_no_resp", resp_valid, 0);
    mem_lat   = 3;
    fill_data = 32'h7777_7777;
    do_req(1'b0, 32'h0000_7004, '0);
    expect_resp("rd_7004_after_rst", 32'h7777_7777, 1'b0);
    do_req(1'b0, 32'h0000_2000, '0);
    expect_resp("rd_2000_after_rst", 32'h7777_7777, 1'b0);
    check_val("post_rst_miss_cnt", miss_cnt, 2);
    check_val("post_rst_hit_cnt", hit_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
